// File: rtl/arb_pkg.sv
// Shared types, constants and the rotating-priority search used by the arbiter.
// Latency: none (package, combinational helper only).
// Backpressure: not applicable.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Search req starting at ptr and wrapping mod NUM_REQ; the first set bit wins.
    // The loop walks from the farthest offset down so the nearest hit overwrites.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/dec2to4_onehot.sv
// Binary index to one-hot decoder with an enable that forces all-zero output.
// Latency: combinational.
// Backpressure: none.
module dec2to4_onehot
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    // Exactly one bit set when enabled, none otherwise.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with grant hold, release hand-off and hold timeout.
// Latency: 1 cycle from req sample to grant; releases hand off back-to-back.
// Backpressure: owner keeps the grant while its req is high, up to MAX_HOLD cycles.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,   // 0 disables the timeout
    parameter int CNT_W    = 5     // needs 2**CNT_W > MAX_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam bit TMO_EN = (MAX_HOLD != 0);
    // With the timeout disabled the counter just parks at all-ones.
    localparam logic [CNT_W-1:0] HOLD_LAST = TMO_EN ? CNT_W'(MAX_HOLD - 1) : '1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] hold_q,  hold_d;
    logic             preempt_q, preempt_d;

    logic [IDX_W-1:0] ptr_after_owner;
    pick_t            pick_idle;
    pick_t            pick_rot;

    // The slot after the owner becomes top priority on release or timeout;
    // that naturally ranks the current owner last.
    assign ptr_after_owner = idx_q + IDX_W'(1);
    assign pick_idle       = rr_pick(req, ptr_q);
    assign pick_rot        = rr_pick(req, ptr_after_owner);

    // Next-state, pointer, hold counter and preempt pulse.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_idle.found) begin
                    state_d = ST_GRANT;
                    idx_d   = pick_idle.idx;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (!req[idx_q]) begin
                    // Release wins over a coincident timeout: no preempt.
                    ptr_d  = ptr_after_owner;
                    hold_d = '0;
                    if (pick_rot.found) begin
                        idx_d = pick_rot.idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (TMO_EN && (hold_q == HOLD_LAST)) begin
                    // Owner still requesting, so a winner always exists;
                    // a lone owner simply gets re-granted.
                    ptr_d     = ptr_after_owner;
                    idx_d     = pick_rot.idx;
                    hold_d    = '0;
                    preempt_d = 1'b1;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt_valid = (state_q == ST_GRANT);
    assign gnt_idx   = idx_q;
    assign preempt   = preempt_q;

    dec2to4_onehot u_dec (
        .idx_i    (idx_q),
        .en_i     (gnt_valid),
        .onehot_o (gnt)
    );

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource. Arbitration produces a 2-bit winner index, and a 2-to-4 one-hot decoder turns it into the per-requester grant lines. A grant is held until the owner releases it or a hold timeout forces rotation. The block sits between requester agents and the shared resource's select logic.

## Interface
- `MAX_HOLD`, default 16: max consecutive cycles one owner may hold the grant; 0 disables the timeout.
- `CNT_W`, default 5: hold-counter width; must satisfy `2**CNT_W > MAX_HOLD`.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req`, input, 4: request per requester, level-held while the resource is wanted.
- `gnt`, output, 4: one-hot grant, registered; all zero when no owner.
- `gnt_idx`, output, 2: binary index of the current owner; valid only when `gnt_valid` = 1.
- `gnt_valid`, output, 1: high while any grant is held.
- `preempt`, output, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- Two states:
  - `IDLE`: no owner.
  - `GRANT`: owner = `gnt_idx`.
- Round-robin pointer `ptr[1:0]` gives the highest-priority candidate. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). The first asserted `req` wins.
- `IDLE` with `req` ≠ 0: the winner is latched, and the state moves to `GRANT`. `hold_cnt` is cleared.
- `IDLE` with `req` = 0: the state stays in `IDLE`, and all outputs stay deasserted.
- `GRANT` with `req[gnt_idx]` = 1 and no timeout: the grant is held, and `hold_cnt` increments.
- `GRANT` with `req[gnt_idx]` = 0 (release):
  - `ptr` ← `gnt_idx`+1, and arbitration runs on the same edge among the other requests, using the new pointer.
  - If a winner is found, the grant switches back-to-back with no idle cycle.
  - If none, the state goes to `IDLE`.
- Timeout: when `MAX_HOLD` ≠ 0, the state is `GRANT`, `hold_cnt` = `MAX_HOLD`-1, and `req[gnt_idx]` = 1:
  - `preempt` pulses on the next cycle.
  - `ptr` ← `gnt_idx`+1, and arbitration runs with the current owner ranked last.
  - If the owner is the only requester, it is re-granted: `gnt` is unchanged, `hold_cnt` restarts at 0, and `preempt` still pulses.
- `gnt` is always the decode of `gnt_idx`, gated by `gnt_valid`. It never has more than one bit set.
- `req` bits for non-owners never disturb the current grant.
- `hold_cnt` saturates at `MAX_HOLD`-1 when the timeout is disabled, and is unused in that case.

## Timing
- All outputs are registered.
- Reset values: `gnt` = 4'b0000, `gnt_idx` = 2'b00, `gnt_valid` = 0, `preempt` = 0, `ptr` = 0, `hold_cnt` = 0, state = `IDLE`.
- Latency from `req` rising (sampled at edge N) to `gnt` visible: 1 cycle, i.e. valid after edge N.
- Latency from owner dropping `req` (sampled at edge N) to `gnt` update: 1 cycle. The new owner's bit rises on the same edge the old one falls.
- Timeout: after `MAX_HOLD` consecutive cycles with `gnt_valid` = 1 for the same owner, the grant changes on the next edge. `preempt` is high for exactly that one cycle.
- A request dropped and re-raised by a non-owner, with no owner edge in between, has no effect.
- Asserting `rst` mid-grant clears all state immediately, without waiting for a clock. Arbitration restarts from `ptr` = 0 on the first edge after `rst` deasserts.
- If the owner releases on the same edge the timeout fires, it is a release: `preempt` stays 0.

## Structure
- Package `arb_pkg`:
  - state enum `{ST_IDLE, ST_GRANT}`.
  - constant `NUM_REQ` = 4.
  - constant `IDX_W` = 2.
  - function `rr_pick(req, ptr)` returning the found flag and the index.
- Sub-module `dec2to4_onehot`: combinational 2-bit index plus enable in, 4-bit one-hot out. The enable forces the output to 0. It is instantiated once to drive `gnt`.
- Top level contains the state register, `ptr`, `hold_cnt`, and the `preempt` register.

## Test plan
- Reset, then `req` = 4'b0000 for 5 cycles: `gnt` = 0000 and `gnt_valid` = 0 throughout. During `rst` = 1 all outputs are at their reset values.
- `req` = 4'b0100 at edge 2: after edge 3, `gnt` = 0100 and `gnt_idx` = 2. Drop `req`: `gnt` = 0000 one cycle later.
- `req` = 4'b1111 held, with each owner dropping its bit after 3 cycles of ownership and re-raising it 1 cycle later: grant order is 0001 → 0010 → 0100 → 1000 → 0001, with no idle gaps between grants.
- `MAX_HOLD` = 4, `req` = 4'b0011 held constant: owner 0 holds for 4 cycles, then `preempt` = 1 for one cycle and `gnt` = 0010. Owner 1 holds 4 cycles, then the grant returns to 0001.
- `MAX_HOLD` = 4, `req` = 4'b1000 alone: after 4 cycles `preempt` pulses once, `gnt` stays 1000, and the pulse repeats every 4 cycles.
- Assert `rst` asynchronously mid-grant (`gnt` = 0100): `gnt` = 0000 before the next clock edge. After release, `req` = 4'b1010 grants 0010 first, because `ptr` = 0.
